// File: rtl/spu_branch_pkg.sv
// Shared types and widths for the SPU ID-stage branch resolver.
package spu_branch_pkg;

  localparam int unsigned DATA_W       = 128;
  localparam int unsigned IDX_W        = 7;
  localparam int unsigned LS_ADDR_W    = 18;
  localparam int unsigned IMM_W        = 16;
  localparam int unsigned LONG_EXTRA   = 1;

  localparam int unsigned WORD_SLOT_HI = 127;
  localparam int unsigned WORD_SLOT_LO = 96;
  localparam int unsigned HALF_SLOT_HI = 111;
  localparam int unsigned HALF_SLOT_LO = 96;
  localparam int unsigned SLOT_W       = WORD_SLOT_HI - WORD_SLOT_LO + 1;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    BR    = 3'd1,
    BRA   = 3'd2,
    BRZ   = 3'd3,
    BRNZ  = 3'd4,
    BRHZ  = 3'd5,
    BRHNZ = 3'd6,
    BI    = 3'd7
  } branch_op_t;

  // BI reads its target from A; the conditional branches test B.
  function automatic logic op_uses_a(input branch_op_t op);
    return op == BI;
  endfunction

  function automatic logic op_uses_b(input branch_op_t op);
    return (op == BRZ) || (op == BRNZ) || (op == BRHZ) || (op == BRHNZ);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// ID-stage branch resolver bus: IF/ID fields, pipeline hazard/forward info, redirect outputs.
interface branch_resolve_unit_if import spu_branch_pkg::*; ();

  logic                 id_valid;
  branch_op_t           id_op;
  logic [LS_ADDR_W-1:0] id_pc;
  logic [IMM_W-1:0]     id_imm;
  logic [IDX_W-1:0]     id_ra_idx;
  logic [IDX_W-1:0]     id_rt_idx;
  logic [DATA_W-1:0]    rf_ra_data;
  logic [DATA_W-1:0]    rf_rt_data;
  logic [IDX_W-1:0]     id_ex_rd_idx;
  logic                 id_ex_wr_en;
  logic                 id_ex_is_long;
  logic [IDX_W-1:0]     ex_mem_rd_idx;
  logic                 ex_mem_wr_en;
  logic [DATA_W-1:0]    ex_mem_result;
  logic                 fwd_sel_a;
  logic                 fwd_sel_b;
  logic                 stall_if_id;
  logic                 redirect_valid;
  logic [LS_ADDR_W-1:0] redirect_pc;
  logic                 flush_if_id;

  modport master (
    output id_valid, id_op, id_pc, id_imm, id_ra_idx, id_rt_idx,
           rf_ra_data, rf_rt_data, id_ex_rd_idx, id_ex_wr_en, id_ex_is_long,
           ex_mem_rd_idx, ex_mem_wr_en, ex_mem_result,
    input  fwd_sel_a, fwd_sel_b, stall_if_id, redirect_valid, redirect_pc, flush_if_id
  );

  modport slave (
    input  id_valid, id_op, id_pc, id_imm, id_ra_idx, id_rt_idx,
           rf_ra_data, rf_rt_data, id_ex_rd_idx, id_ex_wr_en, id_ex_is_long,
           ex_mem_rd_idx, ex_mem_wr_en, ex_mem_result,
    output fwd_sel_a, fwd_sel_b, stall_if_id, redirect_valid, redirect_pc, flush_if_id
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational SPU branch condition and target evaluation on the preferred-slot words.
module branch_cond_eval import spu_branch_pkg::*; (
  input  branch_op_t           op,
  input  logic [SLOT_W-1:0]    a_word,
  input  logic [SLOT_W-1:0]    b_word,
  input  logic [LS_ADDR_W-1:0] pc,
  input  logic [IMM_W-1:0]     imm,
  output logic                 taken,
  output logic [LS_ADDR_W-1:0] target
);

  logic [HALF_SLOT_HI-HALF_SLOT_LO:0] b_half;
  logic [LS_ADDR_W-1:0]               offset;
  logic [LS_ADDR_W-1:0]               bi_target;

  assign b_half = b_word[HALF_SLOT_HI-WORD_SLOT_LO:HALF_SLOT_LO-WORD_SLOT_LO];

  // Word offset becomes a byte offset; everything wraps in the local store.
  assign offset    = {{(LS_ADDR_W-IMM_W){imm[IMM_W-1]}}, imm} << 2;
  assign bi_target = LS_ADDR_W'(a_word & ~SLOT_W'(3));

  always_comb begin
    taken  = 1'b0;
    target = pc + offset;
    case (op)
      BR:      taken = 1'b1;
      BRA: begin
        taken  = 1'b1;
        target = offset;
      end
      BRZ:     taken = (b_word == '0);
      BRNZ:    taken = (b_word != '0);
      BRHZ:    taken = (b_half == '0);
      BRHNZ:   taken = (b_half != '0);
      BI: begin
        taken  = 1'b1;
        target = bi_target;
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolver: operand forwarding, ID/EX hazard stall, registered PC redirect.
module branch_resolve_unit import spu_branch_pkg::*; (
  input logic                  clk,
  input logic                  reset,
  branch_resolve_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(LONG_EXTRA + 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] REDIR = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 redir_q, redir_d;
  logic                 flush_q;
  logic [LS_ADDR_W-1:0] pc_q, pc_d;

  logic                 use_a, use_b;
  logic                 haz_a, haz_b, hazard;
  logic                 fwd_a, fwd_b;
  logic                 stall;
  logic [SLOT_W-1:0]    a_word, b_word;
  logic                 taken;
  logic [LS_ADDR_W-1:0] target;

  assign use_a = bus.id_valid && op_uses_a(bus.id_op);
  assign use_b = bus.id_valid && op_uses_b(bus.id_op);

  // A producer still in ID/EX is younger than EX/MEM, so it wins over forwarding.
  assign haz_a  = use_a && bus.id_ex_wr_en && (bus.id_ex_rd_idx == bus.id_ra_idx);
  assign haz_b  = use_b && bus.id_ex_wr_en && (bus.id_ex_rd_idx == bus.id_rt_idx);
  assign hazard = haz_a || haz_b;

  assign fwd_a = use_a && !haz_a && bus.ex_mem_wr_en && (bus.ex_mem_rd_idx == bus.id_ra_idx);
  assign fwd_b = use_b && !haz_b && bus.ex_mem_wr_en && (bus.ex_mem_rd_idx == bus.id_rt_idx);

  assign a_word = fwd_a ? bus.ex_mem_result[WORD_SLOT_HI:WORD_SLOT_LO]
                        : bus.rf_ra_data[WORD_SLOT_HI:WORD_SLOT_LO];
  assign b_word = fwd_b ? bus.ex_mem_result[WORD_SLOT_HI:WORD_SLOT_LO]
                        : bus.rf_rt_data[WORD_SLOT_HI:WORD_SLOT_LO];

  branch_cond_eval u_cond (
    .op     (bus.id_op),
    .a_word (a_word),
    .b_word (b_word),
    .pc     (bus.id_pc),
    .imm    (bus.id_imm),
    .taken  (taken),
    .target (target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      redir_q <= 1'b0;
      flush_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      redir_q <= redir_d;
      flush_q <= redir_d;
      pc_q    <= pc_d;
    end
  end

  // Next state; REDIR deliberately ignores the wrong-path ID instruction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    redir_d = 1'b0;
    pc_d    = pc_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hazard) begin
          stall   = 1'b1;
          cnt_d   = bus.id_ex_is_long ? CNT_W'(LONG_EXTRA) : '0;
          state_d = STALL;
        end else if (bus.id_valid && taken) begin
          redir_d = 1'b1;
          pc_d    = target;
          state_d = REDIR;
        end
      end
      STALL: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      REDIR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.fwd_sel_a      = fwd_a;
  assign bus.fwd_sel_b      = fwd_b;
  assign bus.stall_if_id    = stall;
  assign bus.redirect_valid = redir_q;
  assign bus.flush_if_id    = flush_q;
  assign bus.redirect_pc    = pc_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- ID-stage branch resolver for the SPU pipeline.
- Selects branch operands from the register file or from the EX/MEM forwarding path.
- Detects hazards on producers still in ID/EX and stalls IF/ID for them.
- Evaluates SPU branch conditions and issues a registered one-cycle PC redirect plus IF/ID flush.
- Sits between the IF/ID register and the fetch PC mux; its forward-select outputs drive the ID-stage operand muxes.

Parameters:
- DATA_W, 128: register width.
- IDX_W, 7: register index width (128 registers; r0 is an ordinary register).
- LS_ADDR_W, 18: local-store byte address width; all PCs wrap modulo 2^LS_ADDR_W.
- LONG_EXTRA, 1: extra stall cycles when the ID/EX producer is a long-latency op (load).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_op  in  3  branch_op_t: NONE, BR, BRA, BRZ, BRNZ, BRHZ, BRHNZ, BI
- id_pc  in  LS_ADDR_W  byte PC of the ID instruction
- id_imm  in  16  signed word offset
- id_ra_idx, id_rt_idx  in  IDX_W  source A (BI target), source B (condition)
- rf_ra_data, rf_rt_data  in  DATA_W  register-file read data
- id_ex_rd_idx  in  IDX_W; id_ex_wr_en  in  1; id_ex_is_long  in  1
- ex_mem_rd_idx  in  IDX_W; ex_mem_wr_en  in  1; ex_mem_result  in  DATA_W
- fwd_sel_a, fwd_sel_b  out  1  1 = operand taken from ex_mem_result
- stall_if_id  out  1  hold PC and IF/ID; insert bubble into ID/EX
- redirect_valid  out  1  registered redirect pulse
- redirect_pc  out  LS_ADDR_W  registered target
- flush_if_id  out  1  registered; asserts with redirect_valid

Behaviour:
- Reset: FSM=IDLE, counter=0. redirect_valid, flush_if_id, stall_if_id, fwd_sel_a and fwd_sel_b are all 0; redirect_pc=0.
- Operand use: BI uses A only. BRZ, BRNZ, BRHZ and BRHNZ use B only. BR, BRA and NONE use no operand.
- Forward select: fwd_sel_x=1 iff the operand is used, ex_mem_wr_en=1 and ex_mem_rd_idx equals the source index. This is combinational.
- Hazard: a used source equals id_ex_rd_idx with id_ex_wr_en=1 and id_valid=1. A hazard overrides forwarding, because the ID/EX producer is younger.
- Condition slot: word = operand[127:96]; halfword = operand[111:96].
  - BRZ: taken when word==0. BRNZ: taken when word!=0.
  - BRHZ: taken when halfword==0. BRHNZ: taken when halfword!=0.
  - BR and BRA: always taken. BI: always taken.
- Targets:
  - BR and conditional branches: id_pc + (sext(id_imm)<<2).
  - BRA: sext(id_imm)<<2.
  - BI: A[127:96] with bits[1:0] cleared.
  - All targets are truncated to LS_ADDR_W (wrap-around).
- FSM state IDLE:
  - Hazard present: stall_if_id=1 (combinational, same cycle). Counter loads 0 for a normal producer, LONG_EXTRA for a long producer. Go to STALL.
  - Otherwise, a taken branch in cycle N gives redirect_valid=1, flush_if_id=1 and redirect_pc=target in cycle N+1. Go to REDIR.
  - Not taken, or NONE: no outputs.
- FSM state STALL:
  - stall_if_id=1 while counter!=0; the counter decrements.
  - When counter==0: stall_if_id=0, go to IDLE, and re-evaluate the next cycle with the (now bubbled) pipeline.
- FSM state REDIR:
  - Lasts exactly one cycle: redirect_valid=1 and flush_if_id=1.
  - ID inputs are ignored because they are the wrong path: no stall and no new redirect.
  - Go to IDLE.
- Redirect_valid is never asserted for two consecutive cycles.
- id_valid=0: no hazard, no redirect, fwd_sel_x=0.
- Both sources forwarded: both selects may be 1.
- Reset asserted mid-STALL or mid-REDIR: outputs return to reset values on the next edge; no pending redirect survives.

Decomposition:
- Package spu_branch_pkg holds:
  - branch_op_t enum
  - LS_ADDR_W
  - WORD_SLOT_HI/LO (127/96) and HALF_SLOT_HI/LO (111/96)
- One combinational sub-module, branch_cond_eval, takes op, operands, pc and imm and returns taken and target.
- FSM, counter, hazard detection and forward selects live in branch_resolve_unit.

Test Plan:
- Forwarded BRZ, taken:
  - Stimulus: id_op=BRZ, rt_idx=5, ex_mem_rd_idx=5, wr_en=1, ex_mem_result[127:96]=0, id_pc=0x100, imm=4.
  - Response: fwd_sel_b=1; next cycle redirect_valid=1, flush_if_id=1, redirect_pc=0x110.
- BRHNZ, not taken:
  - Stimulus: rf_rt_data[111:96]=0, rf_rt_data[127:112]=0xFFFF.
  - Response: no redirect, fwd_sel_b=0.
- ID/EX hazard:
  - Stimulus: id_ex_rd_idx=rt_idx, wr_en=1, is_long=0.
  - Response: stall_if_id=1 for exactly 1 cycle. With is_long=1, LONG_EXTRA=1, stall lasts 2 cycles. After the stall, a match in EX/MEM forwards.
- Wrap-around:
  - Stimulus: BR at id_pc=0x3FFFC, imm=2.
  - Response: redirect_pc=0x00004.
  - Stimulus: BI with A[127:96]=0x12347.
  - Response: redirect_pc=0x12344.
- Back-to-back branches:
  - Stimulus: taken BR, then the next-cycle ID instruction is BRA imm=8.
  - Response: one redirect pulse only, to the first target.
- Reset mid-stall:
  - Stimulus: assert reset during a long-op stall.
  - Response: next cycle stall_if_id=0, FSM IDLE, redirect_valid=0.
